// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline encodings and helpers
package mips_pkg;

  typedef enum logic [1:0] {
    MEM_TO_REG_ALU  = 2'b00,
    MEM_TO_REG_MEM  = 2'b01,
    MEM_TO_REG_LINK = 2'b10,
    MEM_TO_REG_RSVD = 2'b11
  } mem_to_reg_e;

  typedef enum logic [1:0] {
    LOAD_BYTE = 2'b00,
    LOAD_HALF = 2'b01,
    LOAD_WORD = 2'b10,
    LOAD_RSVD = 2'b11
  } load_size_e;

  // Number of bits needed to represent value (clogb2(31) = 5).
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/top_wb_if.sv
// rtl/top_wb_if.sv - MEM/WB entry inputs and register-file write port
interface top_wb_if import mips_pkg::*; #(
  parameter int CANT_REGISTROS      = 32,
  parameter int CANT_BITS_REGISTROS = 32,
  parameter int CANT_BITS_ADDR      = 11
);
  localparam int RW = clogb2(CANT_REGISTROS - 1);

  logic                           i_stall;
  logic                           i_flush;
  logic                           i_valid;
  logic                           i_reg_write_ctrl;
  logic [1:0]                     i_mem_to_reg;
  logic [1:0]                     i_load_size;
  logic                           i_load_unsigned;
  logic                           i_halt;
  logic [RW-1:0]                  i_reg_dest;
  logic [CANT_BITS_REGISTROS-1:0] i_alu_result;
  logic [CANT_BITS_REGISTROS-1:0] i_mem_data;
  logic [CANT_BITS_ADDR-1:0]      i_link_addr;
  logic                           o_control_write_reg;
  logic [RW-1:0]                  o_reg_write;
  logic [CANT_BITS_REGISTROS-1:0] o_data_write;
  logic [31:0]                    o_retired_count;
  logic                           o_halt;

  modport master (
    output i_stall, i_flush, i_valid, i_reg_write_ctrl, i_mem_to_reg, i_load_size,
           i_load_unsigned, i_halt, i_reg_dest, i_alu_result, i_mem_data, i_link_addr,
    input  o_control_write_reg, o_reg_write, o_data_write, o_retired_count, o_halt
  );

  modport slave (
    input  i_stall, i_flush, i_valid, i_reg_write_ctrl, i_mem_to_reg, i_load_size,
           i_load_unsigned, i_halt, i_reg_dest, i_alu_result, i_mem_data, i_link_addr,
    output o_control_write_reg, o_reg_write, o_data_write, o_retired_count, o_halt
  );
endinterface

// File: rtl/top_wb_load_formatter.sv
// rtl/top_wb_load_formatter.sv - little-endian byte/half/word load extraction and extension
module load_formatter import mips_pkg::*; #(
  parameter int W = 32
) (
  input  logic [W-1:0] mem_data,
  input  logic [1:0]   offset,
  input  logic [1:0]   size,
  input  logic         load_unsigned,
  output logic [W-1:0] data
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = mem_data[{offset, 3'b000} +: 8];
    half_v = offset[1] ? mem_data[31:16] : mem_data[15:0];
    case (size)
      LOAD_BYTE: data = {{(W-8){~load_unsigned & byte_v[7]}}, byte_v};
      LOAD_HALF: data = {{(W-16){~load_unsigned & half_v[15]}}, half_v};
      default:   data = mem_data;
    endcase
  end
endmodule

// File: rtl/top_wb.sv
// rtl/top_wb.sv - MIPS write-back stage: MEM/WB register, load format, source mux,
// retired counter and sticky halt.
module top_wb import mips_pkg::*; #(
  parameter int CANT_REGISTROS      = 32,
  parameter int CANT_BITS_REGISTROS = 32,
  parameter int CANT_BITS_ADDR      = 11
) (
  input logic     i_clock,
  input logic     i_soft_reset,
  top_wb_if.slave bus
);
  localparam int RW = clogb2(CANT_REGISTROS - 1);
  localparam int W  = CANT_BITS_REGISTROS;

  logic                      valid_q;
  logic                      reg_write_q;
  logic [1:0]                mem_to_reg_q;
  logic [1:0]                load_size_q;
  logic                      load_unsigned_q;
  logic                      halt_q;
  logic [RW-1:0]             dest_q;
  logic [W-1:0]              alu_q;
  logic [W-1:0]              mem_q;
  logic [CANT_BITS_ADDR-1:0] link_q;
  logic                      halted;
  logic [31:0]               retired_q;
  logic [W-1:0]              load_data;
  logic                      capture;

  assign capture = ~halted & ~bus.i_flush & ~bus.i_stall;

  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      valid_q         <= 1'b0;
      reg_write_q     <= 1'b0;
      mem_to_reg_q    <= 2'b00;
      load_size_q     <= 2'b00;
      load_unsigned_q <= 1'b0;
      halt_q          <= 1'b0;
      dest_q          <= '0;
      alu_q           <= '0;
      mem_q           <= '0;
      link_q          <= '0;
      halted          <= 1'b0;
      retired_q       <= '0;
    end else begin
      if (halted || bus.i_flush) begin
        valid_q <= 1'b0;
      end else if (!bus.i_stall) begin
        valid_q         <= bus.i_valid;
        reg_write_q     <= bus.i_reg_write_ctrl;
        mem_to_reg_q    <= bus.i_mem_to_reg;
        load_size_q     <= bus.i_load_size;
        load_unsigned_q <= bus.i_load_unsigned;
        halt_q          <= bus.i_halt;
        dest_q          <= bus.i_reg_dest;
        alu_q           <= bus.i_alu_result;
        mem_q           <= bus.i_mem_data;
        link_q          <= bus.i_link_addr;
      end
      if (capture && bus.i_valid) begin
        retired_q <= retired_q + 32'd1;
      end
      if (valid_q && halt_q) begin
        halted <= 1'b1;
      end
    end
  end

  load_formatter #(.W(W)) u_load_formatter (
    .mem_data      (mem_q),
    .offset        (alu_q[1:0]),
    .size          (load_size_q),
    .load_unsigned (load_unsigned_q),
    .data          (load_data)
  );

  always_comb begin
    case (mem_to_reg_q)
      MEM_TO_REG_MEM:  bus.o_data_write = load_data;
      MEM_TO_REG_LINK: bus.o_data_write = {{(W-CANT_BITS_ADDR){1'b0}}, link_q};
      default:         bus.o_data_write = alu_q;
    endcase
  end

  // Gating by halted keeps the register file quiet once the debug unit owns the core.
  assign bus.o_control_write_reg = valid_q & reg_write_q & (dest_q != '0) & ~halted;
  assign bus.o_reg_write         = dest_q;
  assign bus.o_retired_count     = retired_q;
  assign bus.o_halt              = halted;
endmodule

// File: tb/tb_top_wb.sv
// tb/tb_top_wb.sv - scoreboard bench for the write-back stage
module tb_top_wb;
  typedef struct {
    string       name;
    logic        en;
    logic [4:0]  rg;
    logic [31:0] data;
    logic        chk_data;
    logic [31:0] cnt;
    logic        halt;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   checks;
  int   errors;

  top_wb_if bus ();

  top_wb dut (
    .i_clock      (clk),
    .i_soft_reset (rst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp(e.name, "en", {31'd0, bus.o_control_write_reg}, {31'd0, e.en});
      cmp(e.name, "count", bus.o_retired_count, e.cnt);
      cmp(e.name, "halt", {31'd0, bus.o_halt}, {31'd0, e.halt});
      if (e.chk_data) begin
        cmp(e.name, "reg", {27'd0, bus.o_reg_write}, {27'd0, e.rg});
        cmp(e.name, "data", bus.o_data_write, e.data);
      end
    end
  end

  task automatic set_in(input logic v, input logic rw, input logic [1:0] m2r, input logic [1:0] sz,
                        input logic uns, input logic hlt, input logic [4:0] dst,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [10:0] link);
    bus.i_valid          = v;
    bus.i_reg_write_ctrl = rw;
    bus.i_mem_to_reg     = m2r;
    bus.i_load_size      = sz;
    bus.i_load_unsigned  = uns;
    bus.i_halt           = hlt;
    bus.i_reg_dest       = dst;
    bus.i_alu_result     = alu;
    bus.i_mem_data       = mem;
    bus.i_link_addr      = link;
  endtask

  task automatic tick(input string nm, input logic en, input logic [4:0] rg, input logic [31:0] data,
                      input logic chkd, input logic [31:0] cnt, input logic halt);
    exp_t e;
    @(posedge clk);
    e.name = nm; e.en = en; e.rg = rg; e.data = data; e.chk_data = chkd; e.cnt = cnt; e.halt = halt;
    exp_q.push_back(e);
    #2;
  endtask

  task automatic expect_reset(input string nm);
    exp_t e;
    e.name = nm; e.en = 1'b0; e.rg = 5'd0; e.data = 32'd0; e.chk_data = 1'b1; e.cnt = 32'd0; e.halt = 1'b0;
    exp_q.push_back(e);
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    checks = 0;
    errors = 0;
    bus.i_stall = 1'b0;
    bus.i_flush = 1'b0;
    set_in(0, 0, 2'b00, 2'b00, 0, 0, 5'd0, 32'd0, 32'd0, 11'd0);
    #1 expect_reset("reset");
    @(negedge clk);
    #1 rst_n = 1'b1;

    set_in(1, 1, 2'b01, 2'b00, 0, 0, 5'd5, 32'd3, 32'h80FF7F01, 11'd0);
    tick("lb_s_off3", 1, 5'd5, 32'hFFFFFF80, 1, 32'd1, 0);
    set_in(1, 1, 2'b01, 2'b00, 1, 0, 5'd5, 32'd3, 32'h80FF7F01, 11'd0);
    tick("lbu_off3", 1, 5'd5, 32'h00000080, 1, 32'd2, 0);
    set_in(1, 1, 2'b01, 2'b01, 0, 0, 5'd6, 32'd2, 32'h80011234, 11'd0);
    tick("lh_off2", 1, 5'd6, 32'hFFFF8001, 1, 32'd3, 0);
    set_in(1, 1, 2'b01, 2'b01, 0, 0, 5'd6, 32'd1, 32'h80011234, 11'd0);
    tick("lh_off1", 1, 5'd6, 32'h00001234, 1, 32'd4, 0);
    set_in(1, 1, 2'b01, 2'b00, 0, 0, 5'd7, 32'd1, 32'h80FF7F01, 11'd0);
    tick("lb_s_off1", 1, 5'd7, 32'h0000007F, 1, 32'd5, 0);
    set_in(1, 1, 2'b01, 2'b10, 0, 0, 5'd8, 32'd0, 32'hDEADBEEF, 11'd0);
    tick("lw", 1, 5'd8, 32'hDEADBEEF, 1, 32'd6, 0);
    set_in(1, 1, 2'b01, 2'b11, 0, 0, 5'd8, 32'd1, 32'h12345678, 11'd0);
    tick("lsize_rsvd", 1, 5'd8, 32'h12345678, 1, 32'd7, 0);
    set_in(1, 1, 2'b00, 2'b00, 0, 0, 5'd9, 32'hCAFEF00D, 32'h11111111, 11'h123);
    tick("alu", 1, 5'd9, 32'hCAFEF00D, 1, 32'd8, 0);
    set_in(1, 1, 2'b11, 2'b00, 0, 0, 5'd9, 32'h01234567, 32'h11111111, 11'h123);
    tick("m2r_rsvd", 1, 5'd9, 32'h01234567, 1, 32'd9, 0);
    set_in(1, 1, 2'b10, 2'b00, 0, 0, 5'd31, 32'hFFFFFFFF, 32'h0, 11'h7FF);
    tick("jal", 1, 5'd31, 32'h000007FF, 1, 32'd10, 0);
    set_in(1, 1, 2'b10, 2'b00, 0, 0, 5'd0, 32'hFFFFFFFF, 32'h0, 11'h7FF);
    tick("dest0", 0, 5'd0, 32'h000007FF, 1, 32'd11, 0);
    set_in(1, 0, 2'b00, 2'b00, 0, 0, 5'd3, 32'h55, 32'h0, 11'h0);
    tick("no_rw", 0, 5'd3, 32'h00000055, 1, 32'd12, 0);

    set_in(1, 1, 2'b00, 2'b00, 0, 0, 5'd7, 32'hA5A5A5A5, 32'h0, 11'h0);
    tick("pre_stall", 1, 5'd7, 32'hA5A5A5A5, 1, 32'd13, 0);
    bus.i_stall = 1'b1;
    set_in(1, 1, 2'b01, 2'b00, 0, 0, 5'd8, 32'h0, 32'hFFFFFFFF, 11'h0);
    for (int i = 0; i < 3; i++) tick("stall", 1, 5'd7, 32'hA5A5A5A5, 1, 32'd13, 0);
    bus.i_flush = 1'b1;
    tick("stall_flush", 0, 5'd0, 32'h0, 0, 32'd13, 0);
    bus.i_stall = 1'b0;
    bus.i_flush = 1'b0;
    set_in(0, 1, 2'b00, 2'b00, 0, 0, 5'd4, 32'h1, 32'h0, 11'h0);
    tick("bubble", 0, 5'd4, 32'h00000001, 1, 32'd13, 0);

    set_in(1, 0, 2'b00, 2'b00, 0, 1, 5'd0, 32'h0, 32'h0, 11'h0);
    tick("halt_cap", 0, 5'd0, 32'h0, 1, 32'd14, 0);
    set_in(0, 0, 2'b00, 2'b00, 0, 0, 5'd0, 32'h0, 32'h0, 11'h0);
    tick("halt_set", 0, 5'd0, 32'h0, 1, 32'd14, 1);
    set_in(1, 1, 2'b00, 2'b00, 0, 0, 5'd5, 32'h77, 32'h0, 11'h0);
    tick("frozen1", 0, 5'd0, 32'h0, 1, 32'd14, 1);
    tick("frozen2", 0, 5'd0, 32'h0, 1, 32'd14, 1);

    @(negedge clk);
    #1 rst_n = 1'b0;
    expect_reset("mid_reset");
    @(negedge clk);
    #1 rst_n = 1'b1;
    set_in(1, 1, 2'b00, 2'b00, 0, 0, 5'd2, 32'h11, 32'h0, 11'h0);
    tick("post_reset", 1, 5'd2, 32'h00000011, 1, 32'd1, 0);

    @(negedge clk);
    #1 force dut.retired_q = 32'hFFFFFFFF;
    #1 release dut.retired_q;
    tick("wrap", 1, 5'd2, 32'h00000011, 1, 32'd0, 0);
    tick("after_wrap", 1, 5'd2, 32'h00000011, 1, 32'd1, 0);

    @(negedge clk);
    @(negedge clk);
    cmp("scoreboard", "drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/top_wb.md
# top_wb

Write-back stage of the MIPS pipeline. It latches the MEM/WB pipeline register and formats load data (byte/half/word, signed/unsigned). It selects the write-back source and drives the register-file write port of the instruction-decode stage (control-write, destination register, write data). It also keeps a retired-instruction counter and a sticky halt flag for the debug unit.

## Interface
Parameters:
- CANT_REGISTROS, 32, number of architectural registers; register address width is clogb2(CANT_REGISTROS-1).
- CANT_BITS_REGISTROS, 32, register/data width.
- CANT_BITS_ADDR, 11, width of the PC/link address.

Ports:
- i_clock  in  1  single clock, rising edge.
- i_soft_reset  in  1  asynchronous, active-low reset.
- i_stall  in  1  hold the pipeline register.
- i_flush  in  1  load a bubble instead of the incoming entry.
- i_valid  in  1  incoming entry is a real instruction.
- i_reg_write_ctrl  in  1  instruction writes a register.
- i_mem_to_reg  in  2  source select: 00 ALU, 01 memory, 10 link, 11 reserved (treated as ALU).
- i_load_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- i_load_unsigned  in  1  zero-extend the load (1) or sign-extend it (0).
- i_halt  in  1  entry is a HALT instruction.
- i_reg_dest  in  clogb2(CANT_REGISTROS-1)  destination register.
- i_alu_result  in  CANT_BITS_REGISTROS  ALU result; bits [1:0] are the load byte offset.
- i_mem_data  in  CANT_BITS_REGISTROS  raw word read from data memory.
- i_link_addr  in  CANT_BITS_ADDR  return address for JAL/JALR.
- o_control_write_reg  out  1  register-file write enable.
- o_reg_write  out  clogb2(CANT_REGISTROS-1)  register-file write address.
- o_data_write  out  CANT_BITS_REGISTROS  register-file write data.
- o_retired_count  out  32  count of captured valid instructions.
- o_halt  out  1  sticky: a HALT has retired.

## Operation
- Pipeline register: stores valid, reg-write control, mem_to_reg, load_size, load_unsigned, halt, dest, alu_result, mem_data and link_addr. It updates on every rising edge, with this priority:
  1. Reset.
  2. Frozen: o_halt=1, the register is held and valid is forced to 0.
  3. i_flush=1: valid_q is cleared to 0; other fields are don't-care.
  4. i_stall=1: all fields are held.
  5. Otherwise: all fields are captured from the inputs.
- Load formatter, little-endian, offset = alu_result_q[1:0]:
  - Byte: mem_data_q[8*offset +: 8].
  - Half: offset[1] selects the half (0 = [15:0], 1 = [31:16]); offset[0] is ignored.
  - Word: passed through unchanged.
  - Byte and half results are extended to the register width with sign or zero fill, per load_unsigned_q.
- Source select: ALU gives alu_result_q; memory gives the formatted load; link gives link_addr_q zero-extended to CANT_BITS_REGISTROS.
- Write outputs:
  - o_control_write_reg = valid_q & reg_write_q & (dest_q != 0). Writes to register 0 are suppressed.
  - o_reg_write = dest_q.
  - o_data_write = selected source; it is driven regardless of the enable.
- Retired counter: increments by 1 on each edge that captures an entry with i_valid=1. It does not count when flush, stall or frozen applies. It wraps 0xFFFFFFFF -> 0.
- Halt: o_halt is set on the edge after valid_q & halt_q is present. It stays 1 until reset.
- Once frozen, o_control_write_reg stays 0 and the counter stops.

## Timing
- Reset values: all pipeline fields 0, o_control_write_reg=0, o_reg_write=0, o_data_write=0, o_retired_count=0, o_halt=0.
- Latency: the write outputs become valid one cycle after capture. They are purely combinational from the register, with no further delay.
- The register file is expected to write on the same edge that next updates this stage.
- A stalled entry re-presents the same write each cycle (idempotent) and is counted once.
- Stall and flush together: flush wins, a bubble is loaded and nothing is counted.
- Reset asserted mid-operation clears all state immediately (asynchronously). Outputs read as reset values until the first edge after deassertion.

## Structure
- Shared package (mips_pkg): clogb2 function, mem_to_reg encodings (MEM_TO_REG_ALU/MEM/LINK) and load-size encodings (LOAD_BYTE/HALF/WORD). The MEM stage and the control unit use the same package.
- One combinational sub-module, load_formatter, with inputs mem_data, offset, size and unsigned, and the formatted word as output.
- The pipeline register, source mux, counter and halt flag live in top_wb.

## Test plan
- Byte load: mem_data=0x80FF7F01, offset=3, byte, signed, dest=5 -> next cycle write enable=1, reg=5, data=0xFFFFFF80. Same with unsigned -> 0x00000080.
- Half load: offset=2, half, signed, mem_data=0x8001_1234 -> data=0xFFFF8001. Offset=1 -> data=0x00001234 (bit 0 ignored).
- JAL: mem_to_reg=10, link_addr=0x7FF, dest=31 -> data=0x000007FF, reg=31, enable=1. dest=0 with reg-write set -> enable=0.
- Stall/flush: capture a valid entry, then hold i_stall for 3 cycles -> outputs unchanged and count=1. Assert stall and flush together -> enable=0 next cycle and count still 1.
- HALT: a valid halt entry is captured -> o_halt=1 on the following edge. Later valid entries -> enable stays 0 and count frozen. Pulse reset low -> all outputs 0.
- Counter wrap: preload to 0xFFFFFFFF by driving 2^32-1 captures (or force in the bench), then one more capture -> 0.
